// File: rtl/gauss_pkg.sv
// gauss_pkg: shared defaults, widths and state type for the Gaussian frame sequencer
package gauss_pkg;
  localparam int ROWS_D = 256;
  localparam int COLS_D = 256;
  localparam int WIDTH_D = 8;
  localparam int FILT_LAT_D = 1;
  localparam int ADDR_W_D = $clog2(ROWS_D);
  localparam int ROW_BITS_D = COLS_D * WIDTH_D;
  typedef enum logic [2:0] {IDLE, READ, PUSH, WAIT, WRITE, DONE} state_t;
endpackage

// File: rtl/gauss_row_counter.sv
// gauss_row_counter: load index k and the row addresses and flags derived from it
module gauss_row_counter
  import gauss_pkg::*;
#(
  parameter int ROWS = ROWS_D,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              primed,
  output logic              skip_nxt,
  output logic              last
);
  localparam int KW = ADDR_W + 1;
  localparam logic [KW-1:0] K_BOT = KW'(ROWS);
  localparam logic [KW-1:0] K_LAST = KW'(ROWS + 1);
  logic [KW-1:0] k;
  always_ff @(posedge clk) begin
    if (rst || clr) k <= '0;
    else if (inc) k <= k + KW'(1);
  end
  // k=1 and k=ROWS+1 reload the same row as the load before them
  always_comb begin
    src = k == '0 ? '0 : k > K_BOT ? ADDR_W'(ROWS - 1) : ADDR_W'(k - KW'(1));
    primed = k >= KW'(2);
    wr_addr = primed ? ADDR_W'(k - KW'(2)) : '0;
    skip_nxt = k == '0 || k == K_BOT;
    last = k == K_LAST;
  end
endmodule

// File: rtl/gaussian_frame_ctrl.sv
// gaussian_frame_ctrl: streams frame rows into a 3x3 Gaussian window and writes filtered rows back
module gaussian_frame_ctrl
  import gauss_pkg::*;
#(
  parameter int ROWS = ROWS_D,
  parameter int COLS = COLS_D,
  parameter int WIDTH = WIDTH_D,
  parameter int FILT_LAT = FILT_LAT_D,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_req,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_ack,
  input  logic [COLS*WIDTH-1:0]  rd_data,
  output logic                   filt_load,
  output logic [COLS*WIDTH-1:0]  filt_row,
  input  logic [COLS*WIDTH-1:0]  filt_out,
  output logic                   wr_req,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [COLS*WIDTH-1:0]  wr_data,
  input  logic                   wr_ack
);
  localparam int CW = $clog2(FILT_LAT + 1);
  localparam logic [CW-1:0] W_END = CW'(FILT_LAT - 1);
  state_t state, nxt;
  logic [CW-1:0] wcnt;
  logic primed, skip_nxt, last, clr, inc;
  gauss_row_counter #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(inc),
    .src(rd_addr),
    .wr_addr(wr_addr),
    .primed(primed),
    .skip_nxt(skip_nxt),
    .last(last)
  );
  // the two priming pushes advance k straight from PUSH; later rows advance after their write
  always_comb begin
    nxt = state;
    inc = 1'b0;
    clr = state == DONE;
    case (state)
      IDLE: nxt = start ? READ : IDLE;
      READ: nxt = rd_ack ? PUSH : READ;
      PUSH: begin
        inc = !primed;
        nxt = primed ? WAIT : skip_nxt ? PUSH : READ;
      end
      WAIT: nxt = wcnt == W_END ? WRITE : WAIT;
      WRITE: begin
        inc = wr_ack && !last;
        nxt = !wr_ack ? WRITE : last ? DONE : skip_nxt ? PUSH : READ;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rd_req <= 1'b0;
      filt_load <= 1'b0;
      wr_req <= 1'b0;
      wcnt <= '0;
      filt_row <= '0;
      wr_data <= '0;
    end else begin
      state <= nxt;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      rd_req <= nxt == READ;
      filt_load <= nxt == PUSH;
      wr_req <= nxt == WRITE;
      wcnt <= state == WAIT ? wcnt + CW'(1) : '0;
      if (state == READ && rd_ack) filt_row <= rd_data;
      if (state == WAIT && wcnt == W_END) wr_data <= filt_out;
    end
  end
endmodule

// File: tb/tb_gaussian_frame_ctrl.sv
// tb_gaussian_frame_ctrl: two sequencers (filter latency 1 and 3) against a frame-level row model
module tb_gaussian_frame_ctrl;
  localparam int R = 4, C = 4, W = 8, AW = 2, RB = C * W;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] start, rst, busy, done, rd_req, rd_ack, filt_load, wr_req, wr_ack;
  logic [AW-1:0] rd_addr [2], wr_addr [2];
  logic [RB-1:0] rd_data [2], filt_row [2], filt_out [2], wr_data [2];
  for (genvar g = 0; g < 2; g++) begin : u
    gaussian_frame_ctrl #(.ROWS(R), .COLS(C), .WIDTH(W), .FILT_LAT(g ? 3 : 1)) dut (
      .clk(clk), .rst(rst[g]), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .rd_req(rd_req[g]), .rd_addr(rd_addr[g]), .rd_ack(rd_ack[g]), .rd_data(rd_data[g]),
      .filt_load(filt_load[g]), .filt_row(filt_row[g]), .filt_out(filt_out[g]),
      .wr_req(wr_req[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]), .wr_ack(wr_ack[g]));
  end
  function automatic logic [RB-1:0] inc_row(input logic [RB-1:0] r);
    for (int j = 0; j < C; j++) inc_row[W*j +: W] = r[W*j +: W] + W'(1);
  endfunction
  function automatic int clamp(input int x);
    return x < 0 ? 0 : x > R - 1 ? R - 1 : x;
  endfunction
  // stub filter: output is the last pushed row plus one, visible after the configured latency
  logic [RB-1:0] pipe [2][3];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (filt_load[g]) pipe[g][0] <= inc_row(filt_row[g]);
      for (int i = 1; i < 3; i++) pipe[g][i] <= pipe[g][i-1];
    end
  end
  assign filt_out[0] = pipe[0][0];
  assign filt_out[1] = pipe[1][2];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit [1:0] act, pend, rp, wp, prev_rst, prev_wr, zw, hold;
  int ri [2], li [2], wi [2], last_load [2], bcyc [2], frames [2], rdly [2], wdly [2], s0 [2];
  logic [AW-1:0] rpa [2], wpa [2];
  logic [RB-1:0] wpd [2];
  logic [RB-1:0] mem [2][R], wlog [2][R];
  task automatic chk(input int g, input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %0h expected %0h at cycle %0d", g, nm, a, e, cyc);
    end
  endtask
  // monitor, memory responder and frame model; everything is sampled mid-cycle
  always @(negedge clk) begin
    bit hr, hw;
    for (int g = 0; g < 2; g++) begin
      if (busy[g] && bcyc[g] == 0) bcyc[g] = cyc;
      if (prev_rst[g])
        chk(g, "reset_outs", {busy[g], done[g], rd_req[g], wr_req[g], filt_load[g], rd_addr[g],
                              wr_addr[g], filt_row[g], wr_data[g]}, '0);
      chk(g, "busy", busy[g], act[g]);
      chk(g, "done", done[g], pend[g]);
      chk(g, "overlap", rd_req[g] & wr_req[g], 0);
      if (rp[g]) chk(g, "rd_hold", {rd_req[g], rd_addr[g]}, {1'b1, rpa[g]});
      if (wp[g]) chk(g, "wr_hold", {wr_req[g], wr_addr[g], wr_data[g]}, {1'b1, wpa[g], wpd[g]});
      if (wr_req[g] && !prev_wr[g]) chk(g, "wait_gap", cyc - last_load[g], g ? 4 : 2);
      if (filt_load[g]) begin
        chk(g, "load_row", filt_row[g], mem[g][clamp(li[g] - 1)]);
        li[g]++;
        last_load[g] = cyc;
      end
      hr = 0;
      hw = 0;
      rd_ack[g] = 1'b0;
      wr_ack[g] = 1'b0;
      rd_data[g] = $urandom;
      if (rd_req[g]) begin
        if (rdly[g] == 0) begin
          hr = 1;
          rd_ack[g] = 1'b1;
          rd_data[g] = mem[g][rd_addr[g]];
          rdly[g] = zw[g] ? 0 : $urandom_range(0, 5);
        end else rdly[g]--;
      end else if (!zw[g]) rd_ack[g] = 1'($urandom_range(0, 1));
      if (wr_req[g]) begin
        if (!hold[g] && wdly[g] == 0) begin
          hw = 1;
          wr_ack[g] = 1'b1;
          wdly[g] = zw[g] ? 0 : $urandom_range(0, 5);
        end else if (!hold[g]) wdly[g]--;
      end else if (!zw[g]) wr_ack[g] = 1'($urandom_range(0, 1));
      if (hr) begin
        chk(g, "rd_addr", rd_addr[g], ri[g]);
        ri[g]++;
      end
      if (hw) begin
        chk(g, "wr_addr", wr_addr[g], wi[g]);
        chk(g, "wr_data", wr_data[g], inc_row(mem[g][clamp(wi[g] + 1)]));
        if (wi[g] < R) wlog[g][wi[g]] = wr_data[g];
        wi[g]++;
      end
      if (pend[g]) begin
        chk(g, "frame_counts", {8'(ri[g]), 8'(li[g]), 8'(wi[g])}, {8'd4, 8'd6, 8'd4});
        if (frames[g] == 0) begin
          chk(g, "t_busy", bcyc[g] - s0[g], 1);
          chk(g, "t_done", cyc - s0[g], g ? 27 : 19);
          chk(g, "lit_w0", wlog[g][0], 32'h21212121);
          chk(g, "lit_w1", wlog[g][1], 32'h31313131);
          chk(g, "lit_w2", wlog[g][2], 32'h41414141);
          chk(g, "lit_w3", wlog[g][3], 32'h41414141);
        end
        frames[g]++;
        ri[g] = 0;
        li[g] = 0;
        wi[g] = 0;
      end
      rp[g] = rd_req[g] && !rd_ack[g];
      rpa[g] = rd_addr[g];
      wp[g] = wr_req[g] && !wr_ack[g];
      wpa[g] = wr_addr[g];
      wpd[g] = wr_data[g];
      prev_wr[g] = wr_req[g];
      if (pend[g]) act[g] = 0;
      else if (start[g]) act[g] = 1;
      pend[g] = hw && wi[g] == R;
      if (rst[g]) begin
        act[g] = 0;
        pend[g] = 0;
        rp[g] = 0;
        wp[g] = 0;
        prev_wr[g] = 0;
        ri[g] = 0;
        li[g] = 0;
        wi[g] = 0;
      end
      prev_rst[g] = rst[g];
    end
    cyc++;
  end
  task automatic wait_on(input int g, input int what);
    int n = 0;
    while (!(what == 0 ? done[g] : what == 1 ? wi[g] == 2 : wr_req[g]) && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    if (n == 1000) begin
      $display("FAIL dut%0d timeout waiting on condition %0d at cycle %0d", g, what, cyc);
      $fatal(1);
    end
  endtask
  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(posedge clk); #2 start[g] = 1'b0;
  endtask
  task automatic randomize_mem(input int g);
    for (int i = 0; i < R; i++) mem[g][i] = $urandom;
  endtask
  task automatic run(input int g);
    @(posedge clk); #2;
    s0[g] = cyc;
    pulse_start(g);
    wait_on(g, 0);
    @(posedge clk); #2 zw[g] = 1'b0;
    for (int f = 0; f < 4; f++) begin
      randomize_mem(g);
      pulse_start(g);
      repeat ($urandom_range(2, 12)) @(posedge clk);
      #2 pulse_start(g);
      wait_on(g, 0);
      pulse_start(g);
    end
    randomize_mem(g);
    pulse_start(g);
    wait_on(g, 1);
    hold[g] = 1'b1;
    wait_on(g, 2);
    repeat (2) @(posedge clk);
    #2 rst[g] = 1'b1;
    @(posedge clk); #2 rst[g] = 1'b0;
    hold[g] = 1'b0;
    repeat (5) @(posedge clk);
    #2 randomize_mem(g);
    pulse_start(g);
    wait_on(g, 0);
    @(posedge clk); #2;
  endtask
  initial begin
    start = '0;
    rst = '1;
    zw = '1;
    hold = '0;
    rd_ack = '0;
    wr_ack = '0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < R; i++) mem[g][i] = {C{8'(8'h10 * (i + 1))}};
    repeat (3) @(posedge clk);
    #2 rst = '0;
    for (int g = 0; g < 2; g++) run(g);
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
